fetch_sequencer: RTL and testbench

//  Run-control FSM sequencing the instruction-fetch stage: start, stall, redirect flush, halt.

---
 rtl/control_pkg.sv | 13 +
 rtl/sat_counter.sv | 20 ++
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared run-control types for the instruction-fetch sequencer.
package control_pkg;

    // Fetch run-control states; the encoding is visible on the debug/trace port.
    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_RUN   = 3'd1,
        FS_STALL = 3'd2,
        FS_FLUSH = 3'd3,
        FS_DONE  = 3'd4
    } e_fetch_state;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for fetch performance statistics.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualifying cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Run-control FSM for the instruction-fetch stage: start, stall, redirect
// flush and halt. Outputs are combinational from the current state and inputs.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating perf counters
// (cycle_cnt, stall_cnt, flush_cnt) and their ports.
module fetch_sequencer
    import control_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             branch_stall_req,
    input  logic             load_hazard_stall,
    input  logic             redirect,
    input  logic             imem_ready,
    output logic             fetch_en,
    output logic             inst_req,
    output logic             pc_en,
    output logic             flush,
    output logic             cpu_done,
    output logic [2:0]       state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int FCNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    // After the redirect cycle itself, FLUSH lasts FLUSH_CYCLES-1 more cycles
    // beyond the one where the counter reaches zero.
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be at least 1");
    end

    e_fetch_state cur, nxt;
    logic [FCNT_W-1:0] fcnt, fcnt_nxt;
    logic stall_any;

    assign stall_any = branch_stall_req | load_hazard_stall | ~imem_ready;
    assign state     = cur;
    assign pc_en     = inst_req;

    // State and flush down-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= FS_IDLE;
            fcnt <= '0;
        end else begin
            cur  <= nxt;
            fcnt <= fcnt_nxt;
        end
    end

    // Next-state and output decode; halt beats redirect beats stall.
    always_comb begin
        nxt      = cur;
        fcnt_nxt = fcnt;
        fetch_en = 1'b0;
        inst_req = 1'b0;
        flush    = 1'b0;
        cpu_done = 1'b0;
        case (cur)
            FS_IDLE: begin
                if (start) nxt = FS_RUN;
            end
            FS_RUN, FS_STALL: begin
                fetch_en = 1'b1;
                if (halt_req) begin
                    inst_req = (cur == FS_RUN) && !stall_any;
                    nxt      = FS_DONE;
                end else if (redirect) begin
                    // Target PC is fetched this cycle; pending stalls are stale.
                    inst_req = imem_ready;
                    flush    = 1'b1;
                    fcnt_nxt = FCNT_LOAD;
                    nxt      = FS_FLUSH;
                end else begin
                    inst_req = (cur == FS_RUN) && !stall_any;
                    nxt      = stall_any ? FS_STALL : FS_RUN;
                end
            end
            FS_FLUSH: begin
                // Hazard stalls and halt come from squashed instructions here.
                fetch_en = 1'b1;
                flush    = 1'b1;
                inst_req = imem_ready;
                if (redirect) begin
                    fcnt_nxt = FCNT_LOAD;
                end else if (fcnt == '0) begin
                    nxt = FS_RUN;
                end else begin
                    fcnt_nxt = fcnt - FCNT_W'(1);
                end
            end
            FS_DONE: begin
                cpu_done = 1'b1;
            end
            default: begin
                nxt = FS_IDLE;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic in_active, in_stall, redirect_acc;

    assign in_active    = (cur == FS_RUN) || (cur == FS_STALL) || (cur == FS_FLUSH);
    assign in_stall     = (cur == FS_STALL);
    assign redirect_acc = redirect &&
                          ((((cur == FS_RUN) || (cur == FS_STALL)) && !halt_req) ||
                           (cur == FS_FLUSH));

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_active),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect_acc),
        .count (flush_cnt)
    );
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an in-bench behavioural model.
// Counter checks are active when FETCH_PERF_CNT_EN is defined.
module tb_fetch_sequencer;

    localparam int FC = 2;
`ifdef FETCH_PERF_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 32;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic halt_req = 1'b0;
    logic branch_stall_req = 1'b0;
    logic load_hazard_stall = 1'b0;
    logic redirect = 1'b0;
    logic imem_ready = 1'b1;
    logic fetch_en, inst_req, pc_en, flush, cpu_done;
    logic [2:0] state;
`ifdef FETCH_PERF_CNT_EN
    logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_sequencer #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .halt_req          (halt_req),
        .branch_stall_req  (branch_stall_req),
        .load_hazard_stall (load_hazard_stall),
        .redirect          (redirect),
        .imem_ready        (imem_ready),
        .fetch_en          (fetch_en),
        .inst_req          (inst_req),
        .pc_en             (pc_en),
        .flush             (flush),
        .cpu_done          (cpu_done),
        .state             (state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .cycle_cnt         (cycle_cnt),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode names the spec state, left = FLUSH cycles still to spend.
    int     m_mode = 0;
    int     m_left = 0;
    logic   m_valid = 1'b0;
    longint m_cyc = 0, m_stl = 0, m_fls = 0;
    longint msat = (64'd1 << CW) - 1;
    logic   sa;

    assign sa = branch_stall_req | load_hazard_stall | ~imem_ready;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_mode  <= 0;
            m_left  <= 0;
            m_cyc   <= 0;
            m_stl   <= 0;
            m_fls   <= 0;
        end else if (m_valid) begin
            if (m_mode >= 1 && m_mode <= 3 && m_cyc < msat) m_cyc <= m_cyc + 1;
            if (m_mode == 2 && m_stl < msat) m_stl <= m_stl + 1;
            if (redirect && (((m_mode == 1 || m_mode == 2) && !halt_req) || m_mode == 3) && m_fls < msat)
                m_fls <= m_fls + 1;
            if (m_mode == 0) begin
                if (start) m_mode <= 1;
            end else if (m_mode == 1 || m_mode == 2) begin
                if (halt_req) m_mode <= 4;
                else if (redirect) begin
                    m_mode <= 3;
                    m_left <= FC;
                end else m_mode <= sa ? 2 : 1;
            end else if (m_mode == 3) begin
                if (redirect) m_left <= FC;
                else begin
                    if (m_left - 1 == 0) m_mode <= 1;
                    m_left <= m_left - 1;
                end
            end
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        logic e_fe, e_ir, e_fl, e_cd;
        if (m_valid) begin
            e_fe = 1'b0; e_ir = 1'b0; e_fl = 1'b0; e_cd = 1'b0;
            if (m_mode == 1 || m_mode == 2) begin
                e_fe = 1'b1;
                if (!halt_req && redirect) begin
                    e_ir = imem_ready;
                    e_fl = 1'b1;
                end else begin
                    e_ir = (m_mode == 1) && !sa;
                end
            end else if (m_mode == 3) begin
                e_fe = 1'b1; e_fl = 1'b1; e_ir = imem_ready;
            end else if (m_mode == 4) begin
                e_cd = 1'b1;
            end
            check("m_state", 32'(state), 32'(m_mode));
            check("m_fetch_en", 32'(fetch_en), 32'(e_fe));
            check("m_inst_req", 32'(inst_req), 32'(e_ir));
            check("m_pc_en", 32'(pc_en), 32'(e_ir));
            check("m_flush", 32'(flush), 32'(e_fl));
            check("m_cpu_done", 32'(cpu_done), 32'(e_cd));
`ifdef FETCH_PERF_CNT_EN
            check("m_cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
            check("m_stall_cnt", 32'(stall_cnt), 32'(m_stl));
            check("m_flush_cnt", 32'(flush_cnt), 32'(m_fls));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        tick(); tick();
        rst = 1'b0; #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'({fetch_en, inst_req, pc_en, flush, cpu_done}), 32'd0);

        // IDLE ignores halt and redirect
        halt_req = 1'b1; redirect = 1'b1; tick();
        halt_req = 1'b0; redirect = 1'b0; #1;
        check("idle_ignore", 32'(state), 32'd0);

        // start -> RUN
        start = 1'b1; tick(); start = 1'b0; #1;
        check("t1_state", 32'(state), 32'd1);
        check("t1_outs", 32'({fetch_en, inst_req, pc_en}), 32'b111);

        // load hazard for three cycles
        load_hazard_stall = 1'b1; #1;
        check("t2_pc_en_run", 32'(pc_en), 32'd0);
        tick(); tick(); tick();
        load_hazard_stall = 1'b0; #1;
        check("t2_stall", 32'(state), 32'd2);
        check("t2_pc_en", 32'(pc_en), 32'd0);
        tick(); #1;
        check("t2_back", 32'(state), 32'd1);

        // redirect with branch stall: flush three cycles, stall ignored
        branch_stall_req = 1'b1; redirect = 1'b1; #1;
        check("t3_req", 32'({inst_req, flush}), 32'b11);
        tick(); redirect = 1'b0; #1;
        check("t3_fl1", 32'({state, flush, inst_req}), 32'b011_1_1);
        tick(); #1;
        check("t3_fl2", 32'({state, flush}), 32'b011_1);
        branch_stall_req = 1'b0;
        tick(); #1;
        check("t3_run", 32'({state, flush}), 32'b001_0);

        // FLUSH: halt ignored, imem not ready, redirect reloads
        redirect = 1'b1; tick(); redirect = 1'b0;
        halt_req = 1'b1; imem_ready = 1'b0; #1;
        check("fl_nready", 32'(inst_req), 32'd0);
        tick(); halt_req = 1'b0; imem_ready = 1'b1;
        redirect = 1'b1; tick(); redirect = 1'b0; #1;
        check("fl_reload", 32'(state), 32'd3);
        tick(); tick(); #1;
        check("fl_exit", 32'(state), 32'd1);

        // halt + redirect in STALL -> DONE, no flush, sticky
        load_hazard_stall = 1'b1; tick(); #1;
        check("t4_stall", 32'(state), 32'd2);
        halt_req = 1'b1; redirect = 1'b1; #1;
        check("t4_noflush", 32'(flush), 32'd0);
        tick(); halt_req = 1'b0; redirect = 1'b0; load_hazard_stall = 1'b0; #1;
        check("t4_done", 32'({state, cpu_done, fetch_en}), 32'b100_1_0);
        start = 1'b1; tick(); start = 1'b0; tick(); #1;
        check("t4_sticky", 32'({state, cpu_done}), 32'b100_1);

        // reset mid-FLUSH
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        redirect = 1'b1; tick(); redirect = 1'b0; #1;
        check("t5_flush", 32'(state), 32'd3);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        check("t5_state", 32'(state), 32'd0);
        check("t5_outs", 32'({fetch_en, inst_req, pc_en, flush, cpu_done}), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("t5_cnts", 32'({cycle_cnt, stall_cnt, flush_cnt}), 32'd0);
`endif

        // long stall: stall counter saturates
        start = 1'b1; tick(); start = 1'b0;
        load_hazard_stall = 1'b1;
        repeat (20) tick();
        load_hazard_stall = 1'b0; #1;
`ifdef FETCH_PERF_CNT_EN
        check("t6_stall_sat", 32'(stall_cnt), 32'hF);
        check("t6_cycle_sat", 32'(cycle_cnt), 32'hF);
`endif
        tick(); #1;
        check("t6_run", 32'(state), 32'd1);

        // plain halt from RUN
        halt_req = 1'b1; tick(); halt_req = 1'b0; #1;
        check("halt_run", 32'({state, cpu_done}), 32'b100_1);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
